fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the decode/control stage. It owns the program counter and issues one request at a time to instruction memory. It buffers one fetched instruction and presents it to decode with a valid/ready handshake. It accepts branch redirects from execute, flushes wrong-path work, and drives a canonical NOP into decode whenever no valid instruction is held.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
NOP_INSTR, 32'h0000_0013, instruction driven to decode when instr_valid=0 (addi x0,x0,0).

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
imem_req  output  1  request strobe; memory accepts every request in the cycle it is high.
imem_addr  output  32  request address; equals the current PC; word-aligned.
imem_rdata  input  32  response data; sampled only when imem_rvalid=1.
imem_rvalid  input  1  response valid; exactly one response per request, 1 or more cycles after the request, in order.
redirect_valid  input  1  one-cycle branch-taken redirect from execute.
redirect_pc  input  32  redirect target; bits [1:0] are forced to 0 internally.
instr  output  32  instruction to decode; equals instr_q when instr_valid=1, else NOP_INSTR.
pc_out  output  32  PC of the instruction on instr.
instr_valid  output  1  the buffer holds a valid instruction.
id_ready  input  1  decode accepts instr this cycle when instr_valid=1.

Behaviour:
- Reset (async, rst=1): pc=RESET_PC, state=IDLE, drop=0, instr_valid=0, instr_q=NOP_INSTR, pc_out=0, imem_req=0. imem_addr follows pc and therefore equals RESET_PC.
- FSM states: IDLE (no request outstanding) and WAIT (one request outstanding). At most one request is outstanding at any time.
- slot_free = !instr_valid || id_ready.
- IDLE: imem_req = slot_free && !redirect_valid. This is combinational; imem_addr=pc.
  - If imem_req=1: go to WAIT and set drop<=0.
  - Otherwise stay in IDLE.
  - An imem_rvalid arriving in IDLE is ignored.
- WAIT: imem_req=0. Stay in WAIT until imem_rvalid=1.
  - On imem_rvalid with drop=0 and no redirect: instr_q<=imem_rdata, pc_out<=pc, instr_valid<=1, pc<=pc+4 (wraps mod 2^32), go to IDLE.
  - On imem_rvalid with drop=1: discard the data, drop<=0, go to IDLE, pc unchanged.
- Invariant: instr_valid=0 whenever state=WAIT. Issue only happens when the buffer is empty or is being consumed in the same cycle.
- Handshake: a transfer occurs when instr_valid && id_ready; on transfer, instr_valid<=0. While instr_valid=1 and id_ready=0, instr and pc_out hold stable.
- Redirect has the highest priority in the cycle it is asserted:
  - pc <= {redirect_pc[31:2],2'b00} and instr_valid<=0 (the buffered instruction is flushed, transfer or not).
  - In IDLE: no request is issued that cycle.
  - In WAIT without imem_rvalid: drop<=1, stay in WAIT.
  - In WAIT with imem_rvalid in the same cycle: the response is discarded, go to IDLE, drop stays 0.
  - Back-to-back redirects: the last one wins.
- Throughput: one instruction per (memory latency + 1) cycles; 2 cycles at latency 1.
- Reset mid-operation clears all state immediately. Memory is reset on the same rst, so no stale response follows.

Test Plan:
- Reset then release, latency-1 memory returning addr as data, id_ready=1 -> requests to 0x0, 0x4, 0x8 on every other cycle; instr_valid pulses with instr=0x0, 0x4, 0x8 and pc_out=0x0, 0x4, 0x8; instr=0x00000013 in the gaps.
- Memory latency 3 -> imem_req high exactly one cycle per fetch; no second request while in WAIT; instr_valid rises 1 cycle after each imem_rvalid.
- id_ready=0 for 5 cycles with instr_valid=1 (instr=0x00500093) -> instr and pc_out stable, imem_req=0; the next request is issued in the same cycle id_ready returns to 1.
- Redirect to 0x100 while in WAIT at latency 3 -> the pending response is discarded and instr_valid stays 0; the next request goes to 0x100 and the first delivered pc_out=0x100.
- redirect_valid coincident with imem_rvalid and with a buffered instruction -> both are discarded; IDLE next cycle; request to the target address.
- redirect_pc=0x0000_0203 -> the next imem_addr is 0x0000_0200. A PC step from 0xFFFF_FFFC wraps to 0x0000_0000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage.
// Owns the program counter, keeps at most one instruction-memory request in
// flight, buffers one fetched instruction for decode and handles branch
// redirects from execute by flushing wrong-path work.
//
// Handshakes:
//   imem side   - imem_req is a one-cycle strobe that memory always accepts;
//                 exactly one imem_rvalid answers each request, in order.
//   decode side - instr/pc_out are offered while instr_valid=1; a transfer
//                 happens on a rising clk edge where instr_valid && id_ready,
//                 and the outputs hold stable while instr_valid && !id_ready.
//
// The FSM state is held in the named signal `state` (IDLE / WAIT) so that
// checkers can bind to it directly.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_rvalid,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] instr,
   output logic [31:0] pc_out,
   output logic        instr_valid,
   input  logic        id_ready
);

   // IDLE: no request outstanding.  WAIT: exactly one request outstanding.
   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [31:0] pc;
   logic [31:0] instr_q;
   logic        drop;

   logic        slot_free;
   logic        transfer;
   logic        resp;
   logic        load;
   logic [31:0] redirect_target;
   logic [31:0] pc_inc;

   // ------------------------------------------------------------------
   // Shared decode of the cycle's events
   // ------------------------------------------------------------------

   // Buffer can take a new instruction if empty or being drained this cycle.
   assign slot_free = !instr_valid || id_ready;

   // Decode consumes the buffered instruction this cycle.
   assign transfer = instr_valid && id_ready;

   // A response is only meaningful while a request is outstanding; a stray
   // imem_rvalid in IDLE is ignored.
   assign resp = (state == WAIT) && imem_rvalid;

   // A response is kept only if it is on the correct path: no earlier
   // redirect marked it for dropping and no redirect arrives with it.
   assign load = resp && !drop && !redirect_valid;

   // Redirect targets are forced word-aligned.
   assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

   // Sequential PC step; wraps naturally modulo 2^32.
   assign pc_inc = pc + 32'd4;

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: issue moves to WAIT, any response returns to IDLE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (imem_req) begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Output logic: request only from IDLE, with room in the buffer and no
   // redirect this cycle; held low while reset is asserted.
   always_comb begin
      imem_req = 1'b0;
      case (state)
         IDLE: begin
            imem_req = slot_free && !redirect_valid && !rst;
         end
         WAIT: begin
            imem_req = 1'b0;
         end
         default: begin
            imem_req = 1'b0;
         end
      endcase
   end

   // The request address is always the current PC.
   assign imem_addr = pc;

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------

   // Program counter: redirect wins, otherwise advance on a kept response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (redirect_valid) begin
         pc <= redirect_target;
      end else if (load) begin
         pc <= pc_inc;
      end
   end

   // Drop flag: marks the outstanding request as wrong-path after a redirect
   // that arrives before its response; cleared when that response lands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop <= 1'b0;
      end else if (imem_req) begin
         drop <= 1'b0;
      end else if (state == WAIT) begin
         if (imem_rvalid) begin
            drop <= 1'b0;
         end else if (redirect_valid) begin
            drop <= 1'b1;
         end
      end
   end

   // Buffer valid: flushed by redirect, set by a kept response, cleared on
   // transfer.  A load only happens in WAIT where the buffer is empty, so a
   // load and a transfer never coincide.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_valid <= 1'b0;
      end else if (redirect_valid) begin
         instr_valid <= 1'b0;
      end else if (load) begin
         instr_valid <= 1'b1;
      end else if (transfer) begin
         instr_valid <= 1'b0;
      end
   end

   // Buffered instruction and its PC, captured together on a kept response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_q <= NOP_INSTR;
         pc_out  <= 32'h0000_0000;
      end else if (load) begin
         instr_q <= imem_rdata;
         pc_out  <= pc;
      end
   end

   // Decode sees a canonical NOP whenever nothing valid is buffered.
   assign instr = instr_valid ? instr_q : NOP_INSTR;

endmodule
